// File: rtl/key_debouncer_pkg.sv
// Shared types and default timing for the key debouncer.
// The defaults assume a 50 MHz clock.
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } rpt_state_e;

    localparam int unsigned CLK_HZ                  = 50_000_000;
    localparam int unsigned DEF_N_KEYS              = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES     = 500_000;     // 10 ms
    localparam int unsigned DEF_HOLD_CYCLES         = 25_000_000;  // 500 ms
    localparam int unsigned DEF_REPEAT_CYCLES       = 5_000_000;   // 100 ms

    // Width of a counter that must reach n without wrapping; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_debouncer_ch.sv
// One key channel: two-flop synchronizer, debounce counter and hold-to-repeat FSM.
// All pulse outputs are registered.
module key_debouncer_ch
    import key_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned DCW     = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RCW     = cnt_width(RPT_MAX);

    localparam logic [DCW-1:0] DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] HOLD_LAST = (HOLD_CYCLES == 0) ? '0 : RCW'(HOLD_CYCLES - 1);
    localparam logic [RCW-1:0] RPT_LAST  = RCW'(REPEAT_CYCLES - 1);

    logic           s1_q, s1_d;
    logic           s2_q, s2_d;
    logic [DCW-1:0] db_cnt_q, db_cnt_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic           repeat_q, repeat_d;
    rpt_state_e     state_q, state_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;

    logic           sync_pressed;
    logic           rise;
    logic           fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            state_q   <= IDLE;
            rcnt_q    <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // Debounce: any cycle where the synchronized key agrees with level restarts the run.
    always_comb begin
        s1_d         = key_n;
        s2_d         = s1_q;
        sync_pressed = ~s2_q;
        db_cnt_d     = '0;
        level_d      = level_q;
        if (sync_pressed != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + DCW'(1);
            end
        end
        rise      = level_d & ~level_q;
        fall      = ~level_d & level_q;
        press_d   = rise;
        release_d = fall;
    end

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        repeat_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HOLD;
                    rcnt_d  = '0;
                end
            end
            HOLD: begin
                // HOLD_CYCLES == 0 parks here forever: repeat disabled.
                if (HOLD_CYCLES != 0) begin
                    if (rcnt_q == HOLD_LAST) begin
                        repeat_d = 1'b1;
                        state_d  = RPT;
                        rcnt_d   = '0;
                    end else begin
                        rcnt_d = rcnt_q + RCW'(1);
                    end
                end
            end
            RPT: begin
                if (rcnt_q == RPT_LAST) begin
                    repeat_d = 1'b1;
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + RCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                rcnt_d  = '0;
            end
        endcase
        // A release always wins over a coincident repeat.
        if (fall) begin
            state_d  = IDLE;
            rcnt_d   = '0;
            repeat_d = 1'b0;
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/key_debouncer.sv
// Multi-channel push-button conditioner: N_KEYS independent debounced channels.
// release/repeat are SystemVerilog keywords, so those outputs carry a _pulse suffix.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int unsigned N_KEYS          = DEF_N_KEYS,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keys_n,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] repeat_pulse
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debouncer_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .key_n         (keys_n[g]),
            .level         (level[g]),
            .press         (press[g]),
            .release_pulse (release_pulse[g]),
            .repeat_pulse  (repeat_pulse[g])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with a cycle-level behavioural model and literal timing checks.
module tb_key_debouncer;

    localparam int NK = 4;
    localparam int DB = 4;
    localparam int HC = 10;
    localparam int RC = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NK-1:0] keys_n = '1;
    logic [NK-1:0] level, press, release_pulse, repeat_pulse;

    key_debouncer #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HC),
        .REPEAT_CYCLES   (RC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .keys_n        (keys_n),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: keys_n seen two edges late, level flips after DB consecutive disagreeing
    // cycles, repeats fall at press+HC, press+HC+RC, ... while level stays high.
    int            cyc = 0;
    bit [NK-1:0]   m_s1 = '1, m_s2 = '1;
    int            m_run [NK];
    int            m_pt  [NK];
    logic [NK-1:0] m_level = '0, m_press = '0, m_rel = '0, m_rep = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1 = '1; m_s2 = '1;
            m_level = '0; m_press = '0; m_rel = '0; m_rep = '0;
            for (int c = 0; c < NK; c++) begin m_run[c] = 0; m_pt[c] = 0; end
        end else begin
            cyc++;
            for (int c = 0; c < NK; c++) begin
                bit held, old;
                int e;
                held    = !m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = keys_n[c];
                old     = m_level[c];
                if (held != old) begin
                    m_run[c]++;
                    if (m_run[c] == DB) begin
                        m_level[c] = !old;
                        m_run[c]   = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_press[c] = !old && m_level[c];
                m_rel[c]   = old && !m_level[c];
                if (m_press[c]) m_pt[c] = cyc;
                m_rep[c] = 1'b0;
                if (old && m_level[c] && HC > 0) begin
                    e = cyc - m_pt[c];
                    if (e >= HC && ((e - HC) % RC) == 0) m_rep[c] = 1'b1;
                end
            end
        end
    end

    int press_edge [NK];
    int rel_edge   [NK];
    int press_cnt  [NK];
    int rel_cnt    [NK];
    int rep_q0[$];

    initial begin
        for (int c = 0; c < NK; c++) begin
            press_edge[c] = -1; rel_edge[c] = -1; press_cnt[c] = 0; rel_cnt[c] = 0;
        end
    end

    always @(negedge clk) begin
        chk("level",   int'(level),         int'(m_level));
        chk("press",   int'(press),         int'(m_press));
        chk("release", int'(release_pulse), int'(m_rel));
        chk("repeat",  int'(repeat_pulse),  int'(m_rep));
        for (int c = 0; c < NK; c++) begin
            if (press[c] === 1'b1)         begin press_edge[c] = cyc; press_cnt[c]++; end
            if (release_pulse[c] === 1'b1) begin rel_edge[c] = cyc;   rel_cnt[c]++;   end
        end
        if (repeat_pulse[0] === 1'b1) rep_q0.push_back(cyc);
    end

    function automatic int rep_at(input int i);
        return (i < rep_q0.size()) ? rep_q0[i] : -1000;
    endfunction

    function automatic int reps_from(input int edge_no);
        int n = 0;
        foreach (rep_q0[i]) if (rep_q0[i] >= edge_no) n++;
        return n;
    endfunction

    function automatic int all_outs();
        return int'({level, press, release_pulse, repeat_pulse});
    endfunction

    initial begin
        int k, p;
        // 1. reset
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_quiet", all_outs(), 0);

        // 2. clean press on key 0
        keys_n[0] = 1'b0; k = cyc + 1;
        repeat (8) @(negedge clk);
        chk("press0_edge", press_edge[0], k + 5);
        chk("press0_count", press_cnt[0], 1);
        chk("level_after_press0", int'(level), 1);
        p = press_edge[0];

        // 4. hold/repeat, then release coinciding with a due repeat
        repeat (20) @(negedge clk);
        chk("rep0_1", rep_at(0) - p, 10);
        chk("rep0_2", rep_at(1) - p, 13);
        chk("rep0_3", rep_at(2) - p, 16);
        chk("rep0_4", rep_at(3) - p, 19);
        keys_n[0] = 1'b1; k = cyc + 1;
        repeat (8) @(negedge clk);
        chk("release0_edge", rel_edge[0], k + 5);
        chk("rep_after_release", reps_from(rel_edge[0]), 0);
        chk("level_after_release0", int'(level), 0);

        // 3. bouncing key 1
        repeat (5) begin
            keys_n[1] = 1'b0;
            repeat (3) @(negedge clk);
            keys_n[1] = 1'b1;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk("bounce_no_press", press_cnt[1], 0);
        chk("bounce_no_level", int'(level[1]), 0);
        keys_n[1] = 1'b0; k = cyc + 1;
        repeat (8) @(negedge clk);
        chk("press1_edge", press_edge[1], k + 5);
        chk("press1_count", press_cnt[1], 1);
        keys_n[1] = 1'b1;
        repeat (8) @(negedge clk);
        chk("release1_count", rel_cnt[1], 1);

        // 5. simultaneous press on keys 0 and 2
        keys_n[0] = 1'b0; keys_n[2] = 1'b0; k = cyc + 1;
        repeat (8) @(negedge clk);
        chk("sim_press0_edge", press_edge[0], k + 5);
        chk("sim_press2_edge", press_edge[2], k + 5);
        chk("sim_press1_count", press_cnt[1], 1);
        chk("sim_press3_count", press_cnt[3], 0);
        chk("sim_level", int'(level), 5);

        // 6. async reset while repeating, key still held
        repeat (14) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("async_rst_outs", all_outs(), 0);
        repeat (2) @(negedge clk);
        chk("in_rst_outs", all_outs(), 0);
        rep_q0.delete();
        rst = 1'b1; k = cyc + 1;
        repeat (8) @(negedge clk);
        chk("rst_repress0_edge", press_edge[0], k + 5);
        chk("rst_repress2_edge", press_edge[2], k + 5);
        p = press_edge[0];
        repeat (12) @(negedge clk);
        chk("rst_first_rep", rep_at(0) - p, 10);

        keys_n = '1;
        repeat (10) @(negedge clk);
        chk("final_level", int'(level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
